// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - LDM/STM/PUSH/POP block transfer sequencer driving RF ports and memory strobes
// Optional macro LDM_PC_BRANCH_EN adds pc_load_o: a load of r15 redirects fetch instead of writing the RF.
module ldm_stm_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int REG_LIST_W = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  is_load_i,
  input  logic                  decr_before_i,
  input  logic                  writeback_i,
  input  logic [3:0]            base_reg_i,
  input  logic [ADDR_W-1:0]     base_val_i,
  input  logic [REG_LIST_W-1:0] reg_list_i,
  output logic [3:0]            rf_rd_addr_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic                  rf_wr_en_o,
  output logic [3:0]            rf_wr_addr_o,
  output logic                  rf_wr_sel_mem_o,
  output logic [ADDR_W-1:0]     wb_data_o,
  output logic                  stall_o,
`ifdef LDM_PC_BRANCH_EN
  output logic                  pc_load_o,
`endif
  output logic                  done_o
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DRAIN,
    S_WB
  } state_t;

  state_t                  state_q, state_d;
  logic [REG_LIST_W-1:0]   list_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W-1:0]       fin_base_q;
  logic                    is_load_q;
  logic                    wb_en_q;
  logic [3:0]              base_reg_q;
  logic                    pend_q;
  logic [3:0]              pend_reg_q;
  logic [ADDR_W-1:0]       pend_addr_q;

  logic [ADDR_W-1:0]       span;
  logic [REG_LIST_W-1:0]   lowest;
  logic [REG_LIST_W-1:0]   rest;
  logic [3:0]              cur_reg;
  logic                    base_in_list;

  // Transfer span, lowest pending register and what remains after it.
  always_comb begin
    span = '0;
    for (int i = 0; i < REG_LIST_W; i++) begin
      if (reg_list_i[i]) span = span + STRIDE;
    end
    lowest  = list_q & (~list_q + REG_LIST_W'(1));
    rest    = list_q & ~lowest;
    cur_reg = '0;
    for (int i = REG_LIST_W - 1; i >= 0; i--) begin
      if (list_q[i]) cur_reg = 4'(i);
    end
    base_in_list = reg_list_i[base_reg_i];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      list_q      <= '0;
      addr_q      <= '0;
      fin_base_q  <= '0;
      is_load_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      base_reg_q  <= '0;
      pend_q      <= 1'b0;
      pend_reg_q  <= '0;
      pend_addr_q <= '0;
    end else begin
      // The op issued in an XFER cycle completes in the following cycle.
      pend_q      <= (state_q == S_XFER);
      pend_reg_q  <= cur_reg;
      pend_addr_q <= addr_q;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            list_q     <= reg_list_i;
            is_load_q  <= is_load_i;
            base_reg_q <= base_reg_i;
            addr_q     <= decr_before_i ? base_val_i - span : base_val_i;
            fin_base_q <= decr_before_i ? base_val_i - span : base_val_i + span;
            wb_en_q    <= writeback_i && (reg_list_i != '0) && !(is_load_i && base_in_list);
          end
        end
        S_XFER: begin
          list_q <= rest;
          addr_q <= addr_q + STRIDE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    rf_rd_addr_o    = '0;
    mem_addr_o      = '0;
    mem_rd_en_o     = 1'b0;
    mem_wr_en_o     = 1'b0;
    rf_wr_en_o      = 1'b0;
    rf_wr_addr_o    = '0;
    rf_wr_sel_mem_o = 1'b0;
    wb_data_o       = '0;
    stall_o         = 1'b0;
    done_o          = 1'b0;
`ifdef LDM_PC_BRANCH_EN
    pc_load_o       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (reg_list_i == '0) ? S_DRAIN : S_XFER;
      end
      S_XFER: begin
        stall_o = 1'b1;
        if (is_load_q) begin
          mem_rd_en_o = 1'b1;
          mem_addr_o  = addr_q;
        end else begin
          rf_rd_addr_o = cur_reg;
        end
        if (rest == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        stall_o = 1'b1;
        if (wb_en_q) begin
          state_d = S_WB;
        end else begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        stall_o      = 1'b1;
        done_o       = 1'b1;
        rf_wr_en_o   = 1'b1;
        rf_wr_addr_o = base_reg_q;
        wb_data_o    = fin_base_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Delayed half of the previous XFER cycle; never overlaps WB.
    if (pend_q) begin
      if (is_load_q) begin
        rf_wr_addr_o    = pend_reg_q;
        rf_wr_sel_mem_o = 1'b1;
`ifdef LDM_PC_BRANCH_EN
        if (pend_reg_q == 4'd15) begin
          pc_load_o = 1'b1;
        end else begin
          rf_wr_en_o = 1'b1;
        end
`else
        rf_wr_en_o = 1'b1;
`endif
      end else begin
        mem_wr_en_o = 1'b1;
        mem_addr_o  = pend_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - randomized self-checking bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        is_load_i;
  logic        decr_before_i;
  logic        writeback_i;
  logic [3:0]  base_reg_i;
  logic [31:0] base_val_i;
  logic [15:0] reg_list_i;
  logic [3:0]  rf_rd_addr_o;
  logic [31:0] mem_addr_o;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic        rf_wr_en_o;
  logic [3:0]  rf_wr_addr_o;
  logic        rf_wr_sel_mem_o;
  logic [31:0] wb_data_o;
  logic        stall_o;
  logic        done_o;
`ifdef LDM_PC_BRANCH_EN
  logic        pc_load_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ldm_stm_sequencer dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .is_load_i       (is_load_i),
    .decr_before_i   (decr_before_i),
    .writeback_i     (writeback_i),
    .base_reg_i      (base_reg_i),
    .base_val_i      (base_val_i),
    .reg_list_i      (reg_list_i),
    .rf_rd_addr_o    (rf_rd_addr_o),
    .mem_addr_o      (mem_addr_o),
    .mem_rd_en_o     (mem_rd_en_o),
    .mem_wr_en_o     (mem_wr_en_o),
    .rf_wr_en_o      (rf_wr_en_o),
    .rf_wr_addr_o    (rf_wr_addr_o),
    .rf_wr_sel_mem_o (rf_wr_sel_mem_o),
    .wb_data_o       (wb_data_o),
    .stall_o         (stall_o),
`ifdef LDM_PC_BRANCH_EN
    .pc_load_o       (pc_load_o),
`endif
    .done_o          (done_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string where);
    check_eq({where, " rf_rd_addr"}, 32'(rf_rd_addr_o), 32'd0);
    check_eq({where, " mem_addr"}, mem_addr_o, 32'd0);
    check_eq({where, " mem_rd_en"}, 32'(mem_rd_en_o), 32'd0);
    check_eq({where, " mem_wr_en"}, 32'(mem_wr_en_o), 32'd0);
    check_eq({where, " rf_wr_en"}, 32'(rf_wr_en_o), 32'd0);
    check_eq({where, " rf_wr_addr"}, 32'(rf_wr_addr_o), 32'd0);
    check_eq({where, " rf_wr_sel_mem"}, 32'(rf_wr_sel_mem_o), 32'd0);
    check_eq({where, " wb_data"}, wb_data_o, 32'd0);
    check_eq({where, " stall"}, 32'(stall_o), 32'd0);
    check_eq({where, " done"}, 32'(done_o), 32'd0);
`ifdef LDM_PC_BRANCH_EN
    check_eq({where, " pc_load"}, 32'(pc_load_o), 32'd0);
`endif
  endtask

  task automatic scramble_inputs();
    is_load_i     = 1'($urandom);
    decr_before_i = 1'($urandom);
    writeback_i   = 1'($urandom);
    base_reg_i    = 4'($urandom);
    base_val_i    = $urandom;
    reg_list_i    = 16'($urandom);
  endtask

  // Called at #1 after a rising edge; that cycle is cycle 0 of the transfer.
  task automatic run_xfer(input logic ld, input logic dec, input logic wb, input logic [3:0] breg,
                          input logic [31:0] base, input logic [15:0] list, input bit busy_start);
    int regs[$];
    int n, last;
    logic [31:0] start_addr, fin;
    bit do_wb, e_rd, e_wr, e_rfw, e_wb, e_pc;

    regs = {};
    for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
    n          = regs.size();
    start_addr = dec ? base - 32'(4 * n) : base;
    fin        = dec ? base - 32'(4 * n) : base + 32'(4 * n);
    do_wb      = wb && (n > 0) && !(ld && list[breg]);
    last       = n + 1 + (do_wb ? 1 : 0);

    start_i = 1'b1; is_load_i = ld; decr_before_i = dec; writeback_i = wb;
    base_reg_i = breg; base_val_i = base; reg_list_i = list;

    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clk_i); #1;
      e_rd  = ld && (c <= n);
      e_wr  = !ld && (c >= 2) && (c <= n + 1);
      e_rfw = ld && (c >= 2) && (c <= n + 1);
      e_wb  = do_wb && (c == last);
      e_pc  = 1'b0;
`ifdef LDM_PC_BRANCH_EN
      if (e_rfw && regs[c-2] == 15) begin
        e_pc  = 1'b1;
        e_rfw = 1'b0;
      end
      check_eq("pc_load", 32'(pc_load_o), 32'(e_pc));
`endif
      check_eq("stall", 32'(stall_o), 32'(c <= last));
      check_eq("done", 32'(done_o), 32'(c == last));
      check_eq("mem_rd_en", 32'(mem_rd_en_o), 32'(e_rd));
      check_eq("mem_wr_en", 32'(mem_wr_en_o), 32'(e_wr));
      check_eq("rf_wr_en", 32'(rf_wr_en_o), 32'(e_rfw || e_wb));
      if (e_rd) check_eq("load addr", mem_addr_o, start_addr + 32'(4 * (c - 1)));
      if (e_wr) check_eq("store addr", mem_addr_o, start_addr + 32'(4 * (c - 2)));
      if (!ld && c <= n) check_eq("rf_rd_addr", 32'(rf_rd_addr_o), 32'(regs[c-1]));
      if (e_rfw || e_pc) begin
        check_eq("load rf_wr_addr", 32'(rf_wr_addr_o), 32'(regs[c-2]));
        check_eq("load sel_mem", 32'(rf_wr_sel_mem_o), 32'd1);
      end
      if (e_wb) begin
        check_eq("wb rf_wr_addr", 32'(rf_wr_addr_o), 32'(breg));
        check_eq("wb sel_mem", 32'(rf_wr_sel_mem_o), 32'd0);
        check_eq("wb data", wb_data_o, fin);
      end
      scramble_inputs();
      if (c <= last) start_i = busy_start ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      else           start_i = 1'b0;
    end
  endtask

  logic [15:0] rl;

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    scramble_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    run_xfer(1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_1000, 16'h4003, 1'b0);
    run_xfer(1'b1, 1'b0, 1'b0, 4'd5,  32'h0000_2000, 16'h0090, 1'b0);
    run_xfer(1'b1, 1'b0, 1'b1, 4'd2,  32'h0000_3000, 16'h0006, 1'b0);
    run_xfer(1'b0, 1'b0, 1'b1, 4'd3,  32'h0000_4000, 16'h0000, 1'b0);
    run_xfer(1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_0004, 16'h0111, 1'b1);
    run_xfer(1'b1, 1'b0, 1'b1, 4'd0,  32'hFFFF_FFFC, 16'hC001, 1'b1);

    // Abort an 8-register load in cycle 2.
    start_i = 1'b1; is_load_i = 1'b1; decr_before_i = 1'b0; writeback_i = 1'b1;
    base_reg_i = 4'd9; base_val_i = 32'h0000_8000; reg_list_i = 16'h00FF;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check_eq("abort c1 rd", 32'(mem_rd_en_o), 32'd1);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    check_all_zero("abort c3");
    @(posedge clk_i); #1;
    check_all_zero("abort c4");
    run_xfer(1'b0, 1'b0, 1'b1, 4'd1, 32'h0000_0100, 16'h0024, 1'b0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       rl = 16'h0000;
        1:       rl = 16'(1 << $urandom_range(0, 15));
        default: rl = 16'($urandom);
      endcase
      run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 16)) : $urandom,
               rl, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
